dot_product_sequencer: RTL and testbench

Sequences a single dot-product job over the operand memories and writes the result into the result memory. It issues VECTOR_WIDTH operand reads from a base address and multiply-accumulates the returned A/B pairs. It writes the truncated sum to an auto-incrementing result slot. It also arbitrates the single result-memory port between its own write and host readback. It sits between the operand-memory writer and the result memory inside the dot-product top level.

---
 rtl/dot_product_pkg.sv | 25 ++
 rtl/dot_product_mac.sv | 45 ++++
 rtl/dot_product_sequencer.sv | 166 ++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// dot_product_pkg
//   Types and constants shared by the dot-product sequencer and its MAC.
//   - state_e          : sequencer FSM states
//   - DEF_*            : default parameter values
//   - result_width()   : accumulator width for a given element width / length
package dot_product_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_VECTOR_WIDTH    = 4;
  localparam int DEF_ADDR_WIDTH      = 5;
  localparam int DEF_MEM3_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Wide enough that VECTOR_WIDTH full-scale products can never overflow.
  function automatic int result_width(input int data_w, input int vec_w);
    return 2 * data_w + $clog2(vec_w);
  endfunction

endpackage

// File: rtl/dot_product_mac.sv
// dot_product_mac
//   Multiply-accumulate datapath for one dot-product job.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     clear_i     : zero the accumulator (job start)
//     rd_en_i     : operand read strobe; data arrives one cycle later
//     a_i, b_i    : operand pair, valid the cycle after rd_en_i
//     acc_o       : running unsigned sum
module dot_product_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    rd_en_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [RESULT_WIDTH-1:0] acc_o
);

  logic                    valid_q;
  logic [RESULT_WIDTH-1:0] acc_q;
  logic [2*DATA_WIDTH-1:0] prod;

  // Zero-extend operands so the product is computed at full width.
  assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      valid_q <= rd_en_i;
      if (clear_i) begin
        acc_q <= '0;
      end else if (valid_q) begin
        acc_q <= acc_q + RESULT_WIDTH'(prod);
      end
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Runs one dot-product job: VECTOR_WIDTH operand reads from base_addr,
//   multiply-accumulate, then writes the low DATA_WIDTH bits of the sum to
//   an auto-incrementing result slot. Shares the result-memory port with
//   host readback (internal write always wins).
//   Ports:
//     start/base_addr         : job request (accepted only when idle)
//     clear_ptr               : zero the result slot pointer
//     op_rd_en/op_rd_addr     : operand memory read; op_*_data one cycle later
//     res_en/res_we/res_addr/res_wdata : result memory port
//     host_rd_req/addr/grant  : host readback arbitration
//     busy, done              : status; done pulses the cycle after the write
//     result_full/trunc       : last complete sum and its overflow-of-byte flag
//     slot_ptr                : next result write address
//     state_dbg_o             : current FSM state for observation
//
// Handshake: host_rd_req is a level held by the host until host_rd_grant is
// seen high in the same cycle; a grant means the read access is on the port
// in that cycle. start is a single-cycle pulse with no back-pressure: if the
// block is busy it is simply dropped.
module dot_product_sequencer
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int VECTOR_WIDTH    = DEF_VECTOR_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int RESULT_WIDTH    = result_width(DATA_WIDTH, VECTOR_WIDTH),
  parameter int MEM3_ADDR_WIDTH = DEF_MEM3_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic                       clear_ptr,
  output logic                       op_rd_en,
  output logic [ADDR_WIDTH-1:0]      op_rd_addr,
  input  logic [DATA_WIDTH-1:0]      op_a_data,
  input  logic [DATA_WIDTH-1:0]      op_b_data,
  output logic                       res_en,
  output logic                       res_we,
  output logic [MEM3_ADDR_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0]      res_wdata,
  input  logic                       host_rd_req,
  input  logic [MEM3_ADDR_WIDTH-1:0] host_rd_addr,
  output logic                       host_rd_grant,
  output logic                       busy,
  output logic                       done,
  output logic [RESULT_WIDTH-1:0]    result_full,
  output logic                       result_trunc,
  output logic [MEM3_ADDR_WIDTH-1:0] slot_ptr,
  output logic [1:0]                 state_dbg_o
);

  localparam int IDX_W = $clog2(VECTOR_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_WIDTH - 1);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [MEM3_ADDR_WIDTH-1:0] slot_q, slot_d;
  logic [RESULT_WIDTH-1:0]    full_q, full_d;
  logic                       trunc_q, trunc_d;
  logic                       done_q, done_d;

  logic                       acc_clear;
  logic                       wr_now;
  logic [RESULT_WIDTH-1:0]    acc;

  dot_product_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(acc_clear),
    .rd_en_i(op_rd_en),
    .a_i    (op_a_data),
    .b_i    (op_b_data),
    .acc_o  (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      full_q  <= '0;
      trunc_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      full_q  <= full_d;
      trunc_q <= trunc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    full_d     = full_q;
    trunc_d    = trunc_q;
    done_d     = 1'b0;
    acc_clear  = 1'b0;
    op_rd_en   = 1'b0;
    op_rd_addr = '0;
    wr_now     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          idx_d     = '0;
          acc_clear = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        op_rd_en   = 1'b1;
        // Address wraps naturally at 2^ADDR_WIDTH.
        op_rd_addr = base_q + ADDR_WIDTH'(idx_q);
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last operand pair is accumulated during this cycle.
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_now  = 1'b1;
        full_d  = acc;
        trunc_d = |acc[RESULT_WIDTH-1:DATA_WIDTH];
        slot_d  = slot_q + MEM3_ADDR_WIDTH'(1);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides the post-write increment; the write itself already
    // used the old pointer.
    if (clear_ptr) slot_d = '0;
  end

  // Result port: internal write has fixed priority over host readback.
  assign host_rd_grant = host_rd_req && (state_q != ST_WRITE);
  assign res_en        = wr_now || host_rd_grant;
  assign res_we        = wr_now;
  assign res_addr      = wr_now        ? slot_q :
                         host_rd_grant ? host_rd_addr : '0;
  assign res_wdata     = acc[DATA_WIDTH-1:0];

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign result_full  = full_q;
  assign result_trunc = trunc_q;
  assign slot_ptr     = slot_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;

  localparam int DW = 8;
  localparam int V  = 4;
  localparam int AW = 5;
  localparam int RW = 2 * DW + $clog2(V);
  localparam int MW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base_addr;
  logic          clear_ptr;
  logic          op_rd_en;
  logic [AW-1:0] op_rd_addr;
  logic [DW-1:0] op_a_data;
  logic [DW-1:0] op_b_data;
  logic          res_en;
  logic          res_we;
  logic [MW-1:0] res_addr;
  logic [DW-1:0] res_wdata;
  logic          host_rd_req;
  logic [MW-1:0] host_rd_addr;
  logic          host_rd_grant;
  logic          busy;
  logic          done;
  logic [RW-1:0] result_full;
  logic          result_trunc;
  logic [MW-1:0] slot_ptr;
  logic [1:0]    state_dbg;

  dot_product_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .clear_ptr    (clear_ptr),
    .op_rd_en     (op_rd_en),
    .op_rd_addr   (op_rd_addr),
    .op_a_data    (op_a_data),
    .op_b_data    (op_b_data),
    .res_en       (res_en),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_wdata    (res_wdata),
    .host_rd_req  (host_rd_req),
    .host_rd_addr (host_rd_addr),
    .host_rd_grant(host_rd_grant),
    .busy         (busy),
    .done         (done),
    .result_full  (result_full),
    .result_trunc (result_trunc),
    .slot_ptr     (slot_ptr),
    .state_dbg_o  (state_dbg)
  );

  // ---------------- operand memory model ----------------
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];

  always @(posedge clk) begin
    if (op_rd_en) begin
      op_a_data <= mem_a[op_rd_addr];
      op_b_data <= mem_b[op_rd_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [MW+RW-1:0] exp_q[$];
  int model_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain sum of products over the wrapped address window.
  function automatic int ref_dot(input int base);
    int s;
    s = 0;
    for (int i = 0; i < V; i++) begin
      s += int'(mem_a[(base + i) % 32]) * int'(mem_b[(base + i) % 32]);
    end
    return s;
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = DW'($urandom_range(0, 255));
      mem_b[i] = DW'($urandom_range(0, 255));
    end
  endfunction

  // ---------------- monitor ----------------
  logic          done_pending = 1'b0;
  logic [RW-1:0] pend_full;

  always @(negedge clk) begin
    logic [MW+RW-1:0] e;
    if (rst_n) begin
      if (done_pending) begin
        chk("done_pulse", done, 1);
        chk("result_full", result_full, pend_full);
        chk("result_trunc", result_trunc, (pend_full >> DW) != 0);
        done_pending = 1'b0;
      end else begin
        chk("done_idle", done, 0);
      end
      if (res_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", res_addr, res_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_slot", res_addr, e[MW+RW-1:RW]);
          chk("write_data", res_wdata, e[DW-1:0]);
          chk("write_en", res_en, 1);
          chk("write_no_grant", host_rd_grant, 0);
          pend_full    = e[RW-1:0];
          done_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after a rising edge with the DUT idle; start is sampled at
  // the next edge (edge 0). Checks cycle-by-cycle timing for cycles 1..V+3.
  task automatic run_job(input int base, input bit host, input bit extra_start,
                         input bit clr, input bit abort);
    int exp_sum;
    chk("idle_before_start", busy, 0);
    exp_sum = ref_dot(base);
    exp_q.push_back({MW'(model_ptr), RW'(exp_sum)});
    start     = 1'b1;
    base_addr = AW'(base);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom_range(0, 31));
    model_ptr = (model_ptr + 1) % 16;
    for (int c = 1; c <= V + 3; c++) begin
      chk("busy", busy, c <= V + 2);
      chk("res_we_timing", res_we, c == V + 2);
      chk("done_timing", done, c == V + 3);
      chk("op_rd_en", op_rd_en, c <= V);
      if (c <= V) chk("op_rd_addr", op_rd_addr, (base + c - 1) % 32);
      if (host) begin
        chk("host_grant", host_rd_grant, c != V + 2);
        if (c != V + 2) begin
          chk("host_res_addr", res_addr, host_rd_addr);
          chk("host_res_we", res_we, 0);
          chk("host_res_en", res_en, 1);
        end
      end
      if (abort && c == 3) begin
        rst_n = 1'b0;
        #1;
        chk("busy_async_reset", busy, 0);
        chk("slot_after_reset", slot_ptr, 0);
        chk("rd_en_after_reset", op_rd_en, 0);
        void'(exp_q.pop_back());
        model_ptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (extra_start && c == 2) begin
        start     = 1'b1;
        base_addr = AW'($urandom_range(0, 31));
      end
      if (extra_start && c == 3) start = 1'b0;
      if (clr && c == V + 2) clear_ptr = 1'b1;
      if (clr && c == V + 3) begin
        clear_ptr = 1'b0;
        model_ptr = 0;
      end
      if (c < V + 3) begin
        @(posedge clk); #1;
      end
    end
    chk("slot_ptr", slot_ptr, model_ptr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b;
    rst_n        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    clear_ptr    = 1'b0;
    host_rd_req  = 1'b0;
    host_rd_addr = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_slot", slot_ptr, 0);
    chk("rst_full", result_full, 0);
    chk("rst_trunc", result_trunc, 0);
    chk("rst_rd_en", op_rd_en, 0);
    chk("rst_rd_addr", op_rd_addr, 0);
    chk("rst_res_en", res_en, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic job: [1,2,3,4].[1,1,1,1] = 10 into slot 0.
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = 8'd1;
    end
    run_job(0, 0, 0, 0, 0);
    chk("basic_sum", result_full, 10);

    // Back-to-back jobs with a dropped start during the first.
    mem_a[4] = 8'd2; mem_a[5] = 8'd4; mem_a[6] = 8'd6; mem_a[7] = 8'd8;
    mem_b[4] = 8'd1; mem_b[5] = 8'd2; mem_b[6] = 8'd3; mem_b[7] = 8'd4;
    mem_a[8] = 8'd0; mem_a[9] = 8'd5; mem_a[10] = 8'd0; mem_a[11] = 8'd3;
    mem_b[8] = 8'd2; mem_b[9] = 8'd0; mem_b[10] = 8'd4; mem_b[11] = 8'd1;
    run_job(4, 0, 1, 0, 0);
    chk("b2b_sum1", result_full, 60);
    run_job(8, 0, 0, 0, 0);
    chk("b2b_sum2", result_full, 3);

    // Truncation: all 255.
    for (int i = 12; i < 16; i++) begin
      mem_a[i] = 8'd255;
      mem_b[i] = 8'd255;
    end
    run_job(12, 0, 0, 0, 0);
    chk("trunc_full", result_full, 260100);
    chk("trunc_flag", result_trunc, 1);

    // Address wrap from base 30.
    run_job(30, 0, 0, 0, 0);

    // Host readback held through a whole job.
    host_rd_addr = MW'($urandom_range(0, 15));
    host_rd_req  = 1'b1;
    run_job($urandom_range(0, 31), 1, 0, 0, 0);
    host_rd_req  = 1'b0;

    // clear_ptr coincident with WRITE.
    run_job($urandom_range(0, 31), 0, 0, 1, 0);
    chk("clear_in_write", slot_ptr, 0);

    // Reset mid-READ, then a clean job.
    fill_random();
    run_job($urandom_range(0, 31), 0, 0, 0, 1);
    run_job($urandom_range(0, 31), 0, 0, 0, 0);

    // 17 consecutive random jobs from slot 0: the 17th lands on slot 0.
    clear_ptr = 1'b1;
    @(posedge clk); #1;
    clear_ptr = 1'b0;
    model_ptr = 0;
    chk("clear_idle", slot_ptr, 0);
    for (int j = 0; j < 17; j++) begin
      fill_random();
      b = $urandom_range(0, 31);
      run_job(b, 0, 0, 0, 0);
    end
    chk("wrap_17_slot", slot_ptr, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
